store_mem_responder: RTL and testbench
======================================

Name: store_mem_responder

Overview:
- Memory-side responder for the kernel store interface. It is the other end of the per-port address/data/valid/ready plus done_valid/done_ready protocol that the conv2d kernels drive.
- Holds a DEPTH x DATA_W register-file memory and arbitrates NUM_PORTS store ports round-robin, one write per cycle.
- Returns one done token per accepted store.
- Provides one load port with 1-cycle latency, used by benches and downstream readers to inspect results.

Parameters:
- NUM_PORTS, 5, number of store ports.
- ADDR_W, 2, address width.
- DATA_W, 64, data width.
- DEPTH, 4, number of memory words (must equal 2**ADDR_W).

Ports:
- clock  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- st_address  in  NUM_PORTS*ADDR_W  per-port store address; port i occupies slice [i*ADDR_W +: ADDR_W].
- st_data  in  NUM_PORTS*DATA_W  per-port store data, sliced the same way.
- st_valid  in  NUM_PORTS  per-port store request valid.
- st_ready  out  NUM_PORTS  per-port store accept.
- st_done_valid  out  NUM_PORTS  per-port store-complete token.
- st_done_ready  in  NUM_PORTS  per-port token consumed.
- ld_address  in  ADDR_W  load address.
- ld_valid  in  1  load request.
- ld_ready  out  1  load accept.
- ld_data  out  DATA_W  load result.
- ld_data_valid  out  1  load result valid.
- ld_data_ready  in  1  load result consumed.

Behaviour:
- Reset (reset low, asynchronous):
  - All memory words = 0.
  - done_pending[i] = 0, so st_done_valid = 0.
  - rr_ptr = 0.
  - ld_data_valid = 0, ld_data = 0.
  - All outputs are 0 while reset is low.
- Eligibility: port i is eligible when st_valid[i] && !done_pending[i]. A port with an unconsumed done token is never accepted again.
- Grant (combinational): the first eligible port scanning from rr_ptr upward, wrapping modulo NUM_PORTS. At most one grant per cycle.
- st_ready[i] = grant[i]. st_ready may depend combinationally on st_valid. Requesters must not wait for ready before asserting valid.
- Store accept (st_valid[i] && st_ready[i]) at edge t:
  - mem[st_address_i] <= st_data_i.
  - done_pending[i] <= 1.
  - rr_ptr <= (i+1) mod NUM_PORTS.
- rr_ptr is unchanged when nothing is granted.
- st_done_valid[i] = done_pending[i]. It rises the cycle after accept, so store-to-done latency is 1 cycle.
- Done token:
  - Held until st_done_ready[i] is high; done_pending[i] clears on that edge.
  - The port becomes eligible again in the following cycle, giving a minimum of 2 cycles per store per port.
  - done_ready with no pending token is ignored.
- Load port:
  - ld_ready = !ld_data_valid || ld_data_ready (1-entry output register).
  - On ld_valid && ld_ready: ld_data <= mem[ld_address] and ld_data_valid <= 1.
  - Otherwise, if ld_data_ready is high, ld_data_valid <= 0.
  - ld_data is held stable while ld_data_valid && !ld_data_ready.
- Load/store same address, same edge: the load returns the pre-write value (read-before-write). The store still commits.
- Address is always in range (DEPTH = 2**ADDR_W); there is no wrap or error path.
- Reset asserted mid-operation: any in-flight done token is discarded, and the write on that edge is lost. Upstream must restart.

Test Plan:
- Reset release, no activity: all st_ready/st_done_valid = 0, ld of addr 0..3 returns 0 each with 1-cycle latency.
- Single store: port 2 writes addr 1 = 64'hDEAD_BEEF_0000_0001 with done_ready=1. Required: st_ready[2] high same cycle, st_done_valid[2] high exactly 1 cycle later for 1 cycle, subsequent load of addr 1 returns that value.
- Contention: ports 0..4 all valid at once, writing data = port index to addr 3, done_ready tied high, rr_ptr=0. Required: grants in order 0,1,2,3,4 on consecutive cycles, final mem[3] = 4.
- Done backpressure: port 1 stores twice with done_ready[1] low for 5 cycles. Required: st_done_valid[1] held for 5 cycles, st_ready[1] stays 0 for the second request until the cycle after done_ready[1] rises. Other ports are still served meanwhile.
- Load backpressure and collision: load addr 0 while port 0 stores 64'h5 to addr 0 on the same edge, with ld_data_ready low for 3 cycles. Required: ld_data = 0 held stable, ld_ready = 0 during stall, next load of addr 0 returns 5.
- Reset mid-operation: assert reset while st_done_valid[3] = 1. Required: st_done_valid falls immediately (asynchronously), memory reads 0 after release, and rr_ptr restarts at 0 (port 0 wins first contention).

Source files
------------

// File: rtl/store_mem_responder_if.sv
// Store/load bus between the conv2d kernels (master) and the memory responder (slave).
//   st_address/st_data/st_valid/st_ready : per-port store request, port i at slice i
//   st_done_valid/st_done_ready          : per-port store-complete token handshake
//   ld_address/ld_valid/ld_ready         : load request handshake
//   ld_data/ld_data_valid/ld_data_ready  : load result handshake
interface store_mem_responder_if #(
   parameter int unsigned NUM_PORTS = 5,
   parameter int unsigned ADDR_W    = 2,
   parameter int unsigned DATA_W    = 64
);
   logic [NUM_PORTS*ADDR_W-1:0] st_address;
   logic [NUM_PORTS*DATA_W-1:0] st_data;
   logic [NUM_PORTS-1:0]        st_valid;
   logic [NUM_PORTS-1:0]        st_ready;
   logic [NUM_PORTS-1:0]        st_done_valid;
   logic [NUM_PORTS-1:0]        st_done_ready;
   logic [ADDR_W-1:0]           ld_address;
   logic                        ld_valid;
   logic                        ld_ready;
   logic [DATA_W-1:0]           ld_data;
   logic                        ld_data_valid;
   logic                        ld_data_ready;

   modport master (
      output st_address, st_data, st_valid, st_done_ready,
      output ld_address, ld_valid, ld_data_ready,
      input  st_ready, st_done_valid, ld_ready, ld_data, ld_data_valid
   );

   modport slave (
      input  st_address, st_data, st_valid, st_done_ready,
      input  ld_address, ld_valid, ld_data_ready,
      output st_ready, st_done_valid, ld_ready, ld_data, ld_data_valid
   );
endinterface

// File: rtl/store_mem_responder.sv
// Memory-side responder for the kernel store interface.
// DEPTH x DATA_W register-file memory, NUM_PORTS store ports arbitrated round-robin
// (one write per cycle), one done token per accepted store, and one load port with a
// 1-entry output register (1-cycle latency, read-before-write against a same-edge store).
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : store_mem_responder_if slave modport (store ports, done tokens, load port)
module store_mem_responder #(
   parameter int unsigned NUM_PORTS = 5,
   parameter int unsigned ADDR_W    = 2,
   parameter int unsigned DATA_W    = 64,
   parameter int unsigned DEPTH     = 4
) (
   input logic                  clock,
   input logic                  reset,
   store_mem_responder_if.slave bus
);
   localparam int unsigned PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

   logic [DATA_W-1:0]    mem_q [DEPTH];
   logic [NUM_PORTS-1:0] done_pending_q;
   logic [PTR_W-1:0]     rr_ptr_q;
   logic [DATA_W-1:0]    ld_data_q;
   logic                 ld_data_valid_q;

   logic [ADDR_W-1:0]    port_addr [NUM_PORTS];
   logic [DATA_W-1:0]    port_data [NUM_PORTS];

   logic [NUM_PORTS-1:0] grant;
   logic                 grant_any;
   logic [PTR_W-1:0]     grant_idx;
   logic [PTR_W-1:0]     rr_ptr_d;
   logic [PTR_W-1:0]     scan_idx;
   int                   scan_sum;
   logic [ADDR_W-1:0]    wr_addr;
   logic [DATA_W-1:0]    wr_data;
   logic                 ld_ready_int;
   logic                 ld_accept;

   for (genvar i = 0; i < NUM_PORTS; i++) begin : g_unpack
      assign port_addr[i] = bus.st_address[i*ADDR_W +: ADDR_W];
      assign port_data[i] = bus.st_data[i*DATA_W +: DATA_W];
   end

   // Scan from rr_ptr upward with wrap; first eligible port wins.
   always_comb begin
      grant     = '0;
      grant_any = 1'b0;
      grant_idx = '0;
      scan_idx  = '0;
      scan_sum  = 0;
      wr_addr   = '0;
      wr_data   = '0;
      for (int k = 0; k < NUM_PORTS; k++) begin
         scan_sum = int'(rr_ptr_q) + k;
         if (scan_sum >= int'(NUM_PORTS)) begin
            scan_sum = scan_sum - int'(NUM_PORTS);
         end
         scan_idx = PTR_W'(scan_sum);
         if (!grant_any && bus.st_valid[scan_idx] && !done_pending_q[scan_idx]) begin
            grant_any         = 1'b1;
            grant[scan_idx]   = 1'b1;
            grant_idx         = scan_idx;
            wr_addr           = port_addr[scan_idx];
            wr_data           = port_data[scan_idx];
         end
      end
   end

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (grant_any) begin
         rr_ptr_d = (grant_idx == PTR_W'(NUM_PORTS - 1)) ? '0 : grant_idx + 1'b1;
      end
   end

   assign ld_ready_int = !ld_data_valid_q || bus.ld_data_ready;
   assign ld_accept    = bus.ld_valid && ld_ready_int;

   // The combinational handshakes are gated so every output is 0 while reset is held.
   assign bus.st_ready      = grant & {NUM_PORTS{reset}};
   assign bus.st_done_valid = done_pending_q;
   assign bus.ld_ready      = ld_ready_int && reset;
   assign bus.ld_data       = ld_data_q;
   assign bus.ld_data_valid = ld_data_valid_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         done_pending_q  <= '0;
         rr_ptr_q        <= '0;
         ld_data_q       <= '0;
         ld_data_valid_q <= 1'b0;
      end else begin
         if (grant_any) begin
            mem_q[wr_addr] <= wr_data;
         end
         // A granted port is never pending, so set and clear never collide.
         done_pending_q <= (done_pending_q & ~bus.st_done_ready) | grant;
         rr_ptr_q       <= rr_ptr_d;
         // Non-blocking read of mem_q yields the pre-write value on a same-edge store.
         if (ld_accept) begin
            ld_data_q       <= mem_q[bus.ld_address];
            ld_data_valid_q <= 1'b1;
         end else if (bus.ld_data_ready) begin
            ld_data_valid_q <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_store_mem_responder.sv
module tb_store_mem_responder;
   localparam int NP    = 5;
   localparam int AW    = 2;
   localparam int DW    = 64;
   localparam int DEPTH = 4;

   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   store_mem_responder_if #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW)) bus ();

   store_mem_responder #(
      .NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
   );

   int checks   = 0;
   int failures = 0;

   // Behavioural model: memory array, pending tokens, next-scan start, load register.
   logic [63:0] mem_m [DEPTH];
   logic [NP-1:0] pend_m;
   int          rr_m;
   logic        ldv_m;
   logic [63:0] ldd_m;
   // Values the model will take after the coming edge.
   logic [63:0] n_mem [DEPTH];
   logic [NP-1:0] n_pend;
   int          n_rr;
   logic        n_ldv;
   logic [63:0] n_ldd;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
      pend_m = '0;
      rr_m   = 0;
      ldv_m  = 1'b0;
      ldd_m  = '0;
   endtask

   task automatic idle();
      bus.st_address    = '0;
      bus.st_data       = '0;
      bus.st_valid      = '0;
      bus.st_done_ready = '1;
      bus.ld_address    = '0;
      bus.ld_valid      = 1'b0;
      bus.ld_data_ready = 1'b1;
   endtask

   task automatic set_port(input int p, input logic [AW-1:0] a, input logic [63:0] d);
      bus.st_address[p*AW +: AW] = a;
      bus.st_data[p*DW +: DW]    = d;
   endtask

   // Called just after a negedge once inputs are driven: compare outputs, plan next state.
   task automatic sample();
      int          g;
      int          idx;
      logic [NP-1:0] exp_ready;
      logic        exp_ldr;
      logic [AW-1:0] a;
      #1;
      g = -1;
      for (int k = 0; k < NP; k++) begin
         idx = (rr_m + k) % NP;
         if (g < 0 && bus.st_valid[idx] && !pend_m[idx]) g = idx;
      end
      exp_ready = '0;
      if (g >= 0) exp_ready[g] = 1'b1;
      exp_ldr = !ldv_m || bus.ld_data_ready;
      chk("st_ready", 64'(bus.st_ready), 64'(exp_ready));
      chk("st_done_valid", 64'(bus.st_done_valid), 64'(pend_m));
      chk("ld_ready", 64'(bus.ld_ready), 64'(exp_ldr));
      chk("ld_data_valid", 64'(bus.ld_data_valid), 64'(ldv_m));
      chk("ld_data", bus.ld_data, ldd_m);

      for (int i = 0; i < DEPTH; i++) n_mem[i] = mem_m[i];
      for (int i = 0; i < NP; i++) n_pend[i] = pend_m[i] && !bus.st_done_ready[i];
      n_rr = rr_m;
      if (g >= 0) begin
         a          = bus.st_address[g*AW +: AW];
         n_mem[a]   = bus.st_data[g*DW +: DW];
         n_pend[g]  = 1'b1;
         n_rr       = (g + 1) % NP;
      end
      n_ldv = ldv_m;
      n_ldd = ldd_m;
      if (bus.ld_valid && exp_ldr) begin
         n_ldv = 1'b1;
         n_ldd = mem_m[bus.ld_address];
      end else if (bus.ld_data_ready) begin
         n_ldv = 1'b0;
      end
   endtask

   task automatic advance();
      @(posedge clock);
      for (int i = 0; i < DEPTH; i++) mem_m[i] = n_mem[i];
      pend_m = n_pend;
      rr_m   = n_rr;
      ldv_m  = n_ldv;
      ldd_m  = n_ldd;
      @(negedge clock);
   endtask

   task automatic step();
      sample();
      advance();
   endtask

   task automatic load_check(input logic [AW-1:0] a, input logic [63:0] exp, input string nm);
      bus.ld_address    = a;
      bus.ld_valid      = 1'b1;
      bus.ld_data_ready = 1'b1;
      step();
      bus.ld_valid = 1'b0;
      sample();
      chk(nm, bus.ld_data, exp);
      advance();
   endtask

   task automatic check_all_zero(input string nm);
      chk({nm, "_st_ready"}, 64'(bus.st_ready), 64'd0);
      chk({nm, "_done_valid"}, 64'(bus.st_done_valid), 64'd0);
      chk({nm, "_ld_ready"}, 64'(bus.ld_ready), 64'd0);
      chk({nm, "_ld_data_valid"}, 64'(bus.ld_data_valid), 64'd0);
      chk({nm, "_ld_data"}, bus.ld_data, 64'd0);
   endtask

   initial begin
      model_reset();
      idle();
      bus.st_valid = '1;
      bus.ld_valid = 1'b1;
      #2;
      check_all_zero("in_reset");
      idle();
      @(negedge clock);
      reset = 1'b1;

      // Idle after reset: every word reads 0 with 1-cycle latency.
      for (int a = 0; a < DEPTH; a++) load_check(AW'(a), 64'd0, "reset_mem");

      // Single store from port 2.
      set_port(2, 2'd1, 64'hDEAD_BEEF_0000_0001);
      bus.st_valid[2] = 1'b1;
      sample();
      chk("single_ready", 64'(bus.st_ready), 64'b00100);
      advance();
      bus.st_valid = '0;
      sample();
      chk("single_done", 64'(bus.st_done_valid), 64'b00100);
      advance();
      sample();
      chk("single_done_drop", 64'(bus.st_done_valid), 64'd0);
      advance();
      load_check(2'd1, 64'hDEAD_BEEF_0000_0001, "single_load");

      // Port 4 store moves the round-robin pointer back to 0.
      set_port(4, 2'd2, 64'h44);
      bus.st_valid[4] = 1'b1;
      step();
      bus.st_valid = '0;
      step();
      step();

      // Contention: all five ports target addr 3, each drops valid once served.
      for (int p = 0; p < NP; p++) set_port(p, 2'd3, 64'(p));
      bus.st_valid = '1;
      for (int k = 0; k < NP; k++) begin
         sample();
         chk("cont_grant", 64'(bus.st_ready), 64'(1) << k);
         advance();
         bus.st_valid[k] = 1'b0;
      end
      step();
      step();
      load_check(2'd3, 64'd4, "cont_final");

      // Load/store collision on addr 0 with load-result backpressure.
      set_port(0, 2'd0, 64'h5);
      bus.st_valid[0]   = 1'b1;
      bus.ld_address    = 2'd0;
      bus.ld_valid      = 1'b1;
      bus.ld_data_ready = 1'b0;
      sample();
      chk("coll_st_ready", 64'(bus.st_ready), 64'b00001);
      advance();
      bus.st_valid = '0;
      bus.ld_valid = 1'b0;
      for (int c = 0; c < 3; c++) begin
         sample();
         chk("coll_hold_data", bus.ld_data, 64'd0);
         chk("coll_ld_ready", 64'(bus.ld_ready), 64'd0);
         advance();
      end
      bus.ld_data_ready = 1'b1;
      load_check(2'd0, 64'd5, "coll_reload");

      // Done backpressure on port 1; port 2 keeps being served meanwhile.
      set_port(1, 2'd2, 64'h1111);
      set_port(2, 2'd1, 64'h2222);
      bus.st_valid[1]      = 1'b1;
      bus.st_done_ready[1] = 1'b0;
      step();
      bus.st_valid[2] = 1'b1;
      for (int c = 0; c < 5; c++) begin
         sample();
         chk("bp_done_held", 64'(bus.st_done_valid[1]), 64'd1);
         chk("bp_ready_low", 64'(bus.st_ready[1]), 64'd0);
         advance();
      end
      bus.st_valid[2]      = 1'b0;
      bus.st_done_ready[1] = 1'b1;
      sample();
      chk("bp_ready_still_low", 64'(bus.st_ready[1]), 64'd0);
      advance();
      sample();
      chk("bp_second_grant", 64'(bus.st_ready), 64'b00010);
      advance();
      bus.st_valid = '0;
      step();

      // Randomised traffic against the model.
      for (int c = 0; c < 400; c++) begin
         for (int p = 0; p < NP; p++) begin
            set_port(p, AW'($urandom_range(0, DEPTH - 1)), {$urandom, $urandom});
            bus.st_valid[p]      = ($urandom_range(0, 1) == 1);
            bus.st_done_ready[p] = ($urandom_range(0, 3) != 0);
         end
         bus.ld_address    = AW'($urandom_range(0, DEPTH - 1));
         bus.ld_valid      = ($urandom_range(0, 1) == 1);
         bus.ld_data_ready = ($urandom_range(0, 3) != 0);
         step();
      end

      // Reset in the middle of a pending done token on port 3.
      idle();
      step();
      set_port(3, 2'd2, 64'h3333);
      bus.st_valid[3]      = 1'b1;
      bus.st_done_ready[3] = 1'b0;
      step();
      bus.st_valid = '1;
      bus.st_done_ready = '0;
      #1;
      chk("mid_done_before", 64'(bus.st_done_valid[3]), 64'd1);
      #1;
      reset = 1'b0;
      #1;
      check_all_zero("mid_reset");
      model_reset();
      idle();
      @(negedge clock);
      reset = 1'b1;
      for (int a = 0; a < DEPTH; a++) load_check(AW'(a), 64'd0, "mid_mem");
      for (int p = 0; p < NP; p++) set_port(p, 2'd0, 64'(p + 10));
      bus.st_valid = '1;
      sample();
      chk("mid_rr_restart", 64'(bus.st_ready), 64'b00001);
      advance();
      idle();
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
